// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between pipeline stages: 1-cycle latency, full throughput, in_ready purely from registered state.
// Optional stall counter output (stall_cnt) is built only when PIPE_SKID_STATS_EN is defined.
module pipe_skid_stage #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rdy_en;
    logic [PC_W-1:0]     r_main_pc;
    logic [INST_W-1:0]   r_main_inst;
    logic [PC_W-1:0]     r_skid_pc;
    logic [INST_W-1:0]   r_skid_inst;

    logic                w_accept;
    logic                w_consume;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    // r_rdy_en keeps in_ready low through reset and the first edge after it.
    assign out_valid = (r_state != EMPTY);
    assign in_ready  = r_rdy_en && (r_state != FULL);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

    assign out_pc   = out_valid ? r_main_pc   : '0;
    assign out_inst = out_valid ? r_main_inst : NOP_INST;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_load_main_in = 1'b1;
                        w_state_nxt    = HALF;
                    end
                end
                HALF: begin
                    if (w_accept && w_consume) begin
                        w_load_main_in = 1'b1;
                    end else if (w_consume) begin
                        w_state_nxt = EMPTY;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (w_consume) begin
                        w_load_main_skid = 1'b1;
                        w_state_nxt      = HALF;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_pc   <= '0;
            r_main_inst <= NOP_INST;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_pc   <= in_pc;
                r_main_inst <= in_inst;
            end else if (w_load_main_skid) begin
                r_main_pc   <= r_skid_pc;
                r_main_inst <= r_skid_inst;
            end
            if (w_load_skid) begin
                r_skid_pc   <= in_pc;
                r_skid_inst <= in_inst;
            end
        end
    end

`ifdef PIPE_SKID_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference model plus directed and randomized traffic.
module tb_pipe_skid_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    logic        in_valid2;
    logic        in_ready2;
    logic [15:0] in_pc2;
    logic [23:0] in_inst2;
    logic        out_valid2;
    logic        out_ready2;
    logic [15:0] out_pc2;
    logic [23:0] out_inst2;

`ifdef PIPE_SKID_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_cnt2;
`endif

    localparam logic [31:0] NOP = 32'h0000_0000;

    int n_checks = 0;
    int n_err    = 0;

    pipe_skid_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
`ifdef PIPE_SKID_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    pipe_skid_stage #(.PC_W(16), .INST_W(24), .NOP_INST(24'h000013)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_pc(in_pc2), .in_inst(in_inst2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_pc(out_pc2), .out_inst(out_inst2)
`ifdef PIPE_SKID_STATS_EN
        , .stall_cnt(stall_cnt2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an ordered queue holding at most two entries.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];
    bit   m_rdy_en = 1'b0;

    function automatic bit m_in_ready();
        return m_rdy_en && (q.size() < 2);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_rdy_en = 1'b0;
        end else begin
            bit   acc;
            bit   con;
            ent_t e;
            acc = in_valid && m_in_ready();
            con = (q.size() > 0) && out_ready;
            e.pc   = in_pc;
            e.inst = in_inst;
            if (flush) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            m_rdy_en = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("model_out_valid", out_valid, q.size() > 0);
        chk("model_in_ready", in_ready, m_in_ready());
        chk("model_out_pc", out_pc, (q.size() > 0) ? q[0].pc : 32'h0);
        chk("model_out_inst", out_inst, (q.size() > 0) ? q[0].inst : NOP);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; in_pc2 = '0; in_inst2 = '0;

        // Reset values before any clock edge
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_inst", out_inst, NOP);
        chk("p2_rst_out_inst", out_inst2, 24'h000013);
        #9 rst = 1'b0;
        in_valid = 1'b1; in_pc = 32'hDEAD_0000; in_inst = 32'h1;
        #1;
        chk("post_rst_pre_edge_in_ready", in_ready, 0);
        tick();
        chk("first_edge_in_ready", in_ready, 1);
        chk("first_edge_no_accept", out_valid, 0);

        // Streaming
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'(4 * i);
            in_inst  = 32'hA000_0000 + 32'(i);
            tick();
            chk("stream_out_valid", out_valid, 1);
            chk("stream_out_pc", out_pc, 4 * i);
            chk("stream_out_inst", out_inst, 32'hA000_0000 + 32'(i));
        end
        in_valid = 1'b0; in_pc = 'x; in_inst = 'x;
        tick();
        chk("stream_drain", out_valid, 0);

        // Skid fill
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h10; in_inst = 32'h110;
        tick();
        chk("skid_half_pc", out_pc, 32'h10);
        chk("skid_half_rdy", in_ready, 1);
        in_pc = 32'h14; in_inst = 32'h114;
        tick();
        chk("skid_full_rdy", in_ready, 0);
        chk("skid_full_pc", out_pc, 32'h10);
        in_valid = 1'b0; in_pc = 'x; in_inst = 'x;
        out_ready = 1'b1;
        tick();
        chk("skid_rel_pc", out_pc, 32'h14);
        chk("skid_rel_rdy", in_ready, 1);
        tick();
        chk("skid_empty", out_valid, 0);

        // Flush while full, with a same-cycle offer
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h18; in_inst = 32'h118;
        tick();
        in_pc = 32'h1C; in_inst = 32'h11C;
        tick();
        chk("flush_pre_full", in_ready, 0);
        flush = 1'b1; in_pc = 32'h20; in_inst = 32'h120;
        tick();
        flush = 1'b0; in_valid = 1'b0; in_pc = 'x; in_inst = 'x;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_inst", out_inst, NOP);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_0x20", out_valid, 0);
        end

        // Asynchronous reset between edges while HALF
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h30; in_inst = 32'h130;
        tick();
        in_valid = 1'b0; in_pc = 'x; in_inst = 'x;
        chk("arst_pre_half", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_imm_out_valid", out_valid, 0);
        chk("arst_imm_out_pc", out_pc, 0);
        chk("arst_imm_in_ready", in_ready, 0);
        tick();
        chk("arst_hold_out_valid", out_valid, 0);
        #2 rst = 1'b0;
        in_valid = 1'b1; in_pc = 32'h34; in_inst = 32'h134;
        #1;
        chk("arst_rel_in_ready", in_ready, 0);
        chk("arst_rel_out_inst", out_inst, NOP);
        tick();
        chk("arst_first_edge_rdy", in_ready, 1);
        chk("arst_first_edge_no_acc", out_valid, 0);
        in_valid = 1'b0; in_pc = 'x; in_inst = 'x;

        // Narrow-parameter instance
        in_valid2 = 1'b1; in_pc2 = 16'hBEEF; in_inst2 = 24'hABCDEF;
        tick();
        in_valid2 = 1'b0;
        chk("p2_out_valid", out_valid2, 1);
        chk("p2_out_pc", out_pc2, 16'hBEEF);
        chk("p2_out_inst", out_inst2, 24'hABCDEF);
        tick();
        chk("p2_idle_inst", out_inst2, 24'h000013);
        chk("p2_idle_pc", out_pc2, 0);

`ifdef PIPE_SKID_STATS_EN
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("stats_clear", stall_cnt, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h40; in_inst = 32'h140;
        tick();
        in_valid = 1'b0; in_pc = 'x; in_inst = 'x;
        repeat (5) tick();
        chk("stats_five", stall_cnt, 5);
        repeat (70000) tick();
        chk("stats_saturate", stall_cnt, 16'hFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("stats_flush", stall_cnt, 0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 50) == 0;
            if (in_valid) begin
                in_pc   = $urandom;
                in_inst = $urandom;
            end else begin
                in_pc   = 'x;
                in_inst = 'x;
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("final_drain", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
